// File: rtl/neopixel_framebuf_if.sv
// Pixel-source / serialiser-side bundle for neopixel_framebuf.
// master: pixel source plus frame-sync driver; slave: the frame buffer.
interface neopixel_framebuf_if;
    logic         wr_valid;
    logic         wr_ready;
    logic [3:0]   wr_index;
    logic [23:0]  wr_rgb;
    logic         commit;
    logic [7:0]   brightness;
    logic         frame_sync;
    logic         busy;
    logic         swap_done;
    logic [383:0] framebuf;

    modport master (
        output wr_valid, wr_index, wr_rgb, commit, brightness, frame_sync,
        input  wr_ready, busy, swap_done, framebuf
    );

    modport slave (
        input  wr_valid, wr_index, wr_rgb, commit, brightness, frame_sync,
        output wr_ready, busy, swap_done, framebuf
    );
endinterface

// File: rtl/neopixel_framebuf.sv
// neopixel_framebuf: double-buffered 16-pixel store feeding the NeoPixel
// serialiser. Pixels land in a back buffer, a commit copies it byte by byte
// (48 cycles) into staging, and staging becomes the visible front buffer only
// on the serialiser's frame_sync pulse, so a frame is never torn.
// Optional feature: define NEOPIXEL_FB_BRIGHTNESS_EN to scale every byte by
// (brightness + 1) / 256 during the copy; otherwise bytes copy unchanged.
module neopixel_framebuf #(
    parameter int NUM_PIXELS = 16,
    parameter int BYTES      = NUM_PIXELS * 3
) (
    input  logic                clk,
    input  logic                rst,
    neopixel_framebuf_if.slave  bus
);

    localparam int FB_W  = BYTES * 8;
    localparam int PTR_W = $clog2(BYTES);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SCALE     = 2'd1,
        S_WAIT_SYNC = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   byte_ptr_q, byte_ptr_d;
    logic [FB_W-1:0]    back_q;
    logic [FB_W-1:0]    stage_q;
    logic [FB_W-1:0]    front_q;
    logic               swap_done_q;

    // Control strobes decoded by the FSM.
    logic               wr_ready_c;
    logic               busy_c;
    logic               commit_go;
    logic               scale_en;
    logic               swap_go;
    logic               wr_fire;

    // Byte currently walked by the copy engine and its transformed value.
    logic [7:0]         src_byte;
    logic [7:0]         dst_byte;

`ifdef NEOPIXEL_FB_BRIGHTNESS_EN
    logic [7:0]         bri_q;
    logic [16:0]        prod;
`endif

    assign wr_fire = bus.wr_valid && wr_ready_c;

    // State register and copy-engine byte pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            byte_ptr_q <= byte_ptr_d;
        end
    end

    // Next-state logic plus the strobes that steer the datapath; wr_ready and
    // busy come straight from the state so they change the instant it does.
    always_comb begin
        state_d    = state_q;
        byte_ptr_d = byte_ptr_q;
        wr_ready_c = 1'b0;
        busy_c     = 1'b0;
        commit_go  = 1'b0;
        scale_en   = 1'b0;
        swap_go    = 1'b0;
        case (state_q)
            S_IDLE: begin
                wr_ready_c = 1'b1;
                if (bus.commit) begin
                    commit_go  = 1'b1;
                    byte_ptr_d = '0;
                    state_d    = S_SCALE;
                end
            end
            S_SCALE: begin
                busy_c   = 1'b1;
                scale_en = 1'b1;
                if (byte_ptr_q == PTR_W'(BYTES - 1)) begin
                    state_d = S_WAIT_SYNC;
                end else begin
                    byte_ptr_d = byte_ptr_q + 1'b1;
                end
            end
            S_WAIT_SYNC: begin
                busy_c = 1'b1;
                if (bus.frame_sync) begin
                    swap_go = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Select the back-buffer byte under the pointer and apply f(x).
    always_comb begin
        src_byte = back_q[{byte_ptr_q, 3'b000} +: 8];
`ifdef NEOPIXEL_FB_BRIGHTNESS_EN
        // x * (bri + 1) fits in 16 bits (max 255*256), so >>8 then truncate
        // keeps exactly the integer part of the scaled value.
        prod     = 17'(src_byte) * (17'(bri_q) + 17'd1);
        dst_byte = 8'(prod >> 8);
`else
        dst_byte = src_byte;
`endif
    end

`ifdef NEOPIXEL_FB_BRIGHTNESS_EN
    // Brightness is frozen at commit so a frame scales uniformly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bri_q <= '0;
        end else if (commit_go) begin
            bri_q <= bus.brightness;
        end
    end
`endif

    // Back buffer: only the pixel source writes it; it persists across commits.
    // A write in the commit cycle lands before SCALE starts reading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            back_q <= '0;
        end else if (wr_fire) begin
            back_q[24 * bus.wr_index +: 24] <= bus.wr_rgb;
        end
    end

    // Staging buffer: filled one byte per SCALE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else if (scale_en) begin
            stage_q[{byte_ptr_q, 3'b000} +: 8] <= dst_byte;
        end
    end

    // Front buffer and swap pulse: updated only inside the sync window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_q     <= '0;
            swap_done_q <= 1'b0;
        end else begin
            swap_done_q <= swap_go;
            if (swap_go) begin
                front_q <= stage_q;
            end
        end
    end

    assign bus.wr_ready  = wr_ready_c;
    assign bus.busy      = busy_c;
    assign bus.swap_done = swap_done_q;
    assign bus.framebuf  = front_q;

endmodule

// File: tb/tb_neopixel_framebuf.sv
// Directed bench for neopixel_framebuf: a vector table of write/commit/sync
// transactions with hand-computed pixel results, plus hand-written sequences
// for reset, sync gating, backpressure and same-cycle write+commit.
module tb_neopixel_framebuf;

    logic clk;
    logic rst;
    neopixel_framebuf_if ifc ();

    neopixel_framebuf dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int acc_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifc.wr_valid && ifc.wr_ready) acc_cnt <= acc_cnt + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int t0     = 0;

    typedef struct {
        logic [3:0]  idx;
        logic [23:0] rgb;
        logic [7:0]  bri;
        int          sync_at;
        logic [23:0] exp_on;
        logic [23:0] exp_off;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_px(input logic [3:0] idx, input logic [23:0] rgb);
        ifc.wr_valid = 1'b1;
        ifc.wr_index = idx;
        ifc.wr_rgb   = rgb;
        tick();
        ifc.wr_valid = 1'b0;
    endtask

    task automatic do_commit(input logic [7:0] bri);
        ifc.commit     = 1'b1;
        ifc.brightness = bri;
        tick();
        ifc.commit = 1'b0;
        t0 = cyc;
    endtask

    // Raise frame_sync so it is sampled at edge t0 + k.
    task automatic sync_at(input int k);
        while (cyc < t0 + k - 1) tick();
        ifc.frame_sync = 1'b1;
        tick();
        ifc.frame_sync = 1'b0;
    endtask

    function automatic logic [23:0] px(input logic [383:0] fb, input int i);
        return fb[24 * i +: 24];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [383:0] e;
        int a0;
        logic [23:0] ex;

        //            idx    rgb          bri    sync exp_on       exp_off
        vecs[0] = '{4'd3,  24'h112233, 8'd255, 49, 24'h112233, 24'h112233};
        vecs[1] = '{4'd0,  24'hFFFFFF, 8'd127, 55, 24'h7F7F7F, 24'hFFFFFF};
        vecs[2] = '{4'd7,  24'h808080, 8'd0,   50, 24'h000000, 24'h808080};
        vecs[3] = '{4'd15, 24'h102030, 8'd63,  49, 24'h04080C, 24'h102030};
        vecs[4] = '{4'd9,  24'hFF0001, 8'd1,   70, 24'h010000, 24'hFF0001};
        vecs[5] = '{4'd5,  24'h80C0FF, 8'd191, 52, 24'h6090BF, 24'h80C0FF};

        rst = 1'b0;
        ifc.wr_valid = 1'b0; ifc.wr_index = '0; ifc.wr_rgb = '0;
        ifc.commit = 1'b0; ifc.brightness = 8'd255; ifc.frame_sync = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        chk("reset_framebuf", ifc.framebuf, '0);
        chk("reset_wr_ready", 384'(ifc.wr_ready), 384'(1));
        chk("reset_busy", 384'(ifc.busy), 384'(0));
        chk("reset_swap_done", 384'(ifc.swap_done), 384'(0));

        // Basic frame
        wr_px(4'd3, 24'h112233);
        do_commit(8'd255);
        chk("basic_busy_after_commit", 384'(ifc.busy), 384'(1));
        chk("basic_wr_ready_after_commit", 384'(ifc.wr_ready), 384'(0));
        chk("basic_fb_before_swap", ifc.framebuf, '0);
        sync_at(60);
        e = '0; e[95:72] = 24'h112233;
        chk("basic_framebuf", ifc.framebuf, e);
        chk("basic_swap_done", 384'(ifc.swap_done), 384'(1));
        chk("basic_busy_done", 384'(ifc.busy), 384'(0));
        chk("basic_wr_ready_done", 384'(ifc.wr_ready), 384'(1));
        tick();
        chk("basic_swap_done_single", 384'(ifc.swap_done), 384'(0));

        // Sync gating: pulses at T+20 and T+48 ignored, T+49 swaps
        wr_px(4'd4, 24'h445566);
        do_commit(8'd255);
        sync_at(20);
        chk("gate20_swap_done", 384'(ifc.swap_done), 384'(0));
        chk("gate20_px4", 384'(px(ifc.framebuf, 4)), 384'(0));
        sync_at(48);
        chk("gate48_swap_done", 384'(ifc.swap_done), 384'(0));
        chk("gate48_busy", 384'(ifc.busy), 384'(1));
        chk("gate48_px4", 384'(px(ifc.framebuf, 4)), 384'(0));
        sync_at(49);
        chk("gate49_swap_done", 384'(ifc.swap_done), 384'(1));
        chk("gate49_px4", 384'(px(ifc.framebuf, 4)), 384'(24'h445566));
        chk("gate49_px3", 384'(px(ifc.framebuf, 3)), 384'(24'h112233));

        // Backpressure: write and commit held across busy
        do_commit(8'd255);
        a0 = acc_cnt;
        ifc.wr_valid = 1'b1; ifc.wr_index = 4'd2; ifc.wr_rgb = 24'hAAAAAA;
        ifc.commit = 1'b1;
        repeat (55) tick();
        chk("bp_no_accept_busy", 384'(acc_cnt - a0), 384'(0));
        chk("bp_wr_ready_low", 384'(ifc.wr_ready), 384'(0));
        ifc.commit = 1'b0;
        ifc.frame_sync = 1'b1;
        tick();
        ifc.frame_sync = 1'b0;
        chk("bp_px2_not_in_frame", 384'(px(ifc.framebuf, 2)), 384'(0));
        tick();
        ifc.wr_valid = 1'b0;
        chk("bp_one_accept", 384'(acc_cnt - a0), 384'(1));
        chk("bp_commit_not_queued", 384'(ifc.busy), 384'(0));
        tick(); tick();
        chk("bp_still_one_accept", 384'(acc_cnt - a0), 384'(1));
        do_commit(8'd255);
        sync_at(49);
        chk("bp_px2_published", 384'(px(ifc.framebuf, 2)), 384'(24'hAAAAAA));

        // Same-cycle write and commit
        ifc.wr_valid = 1'b1; ifc.wr_index = 4'd15; ifc.wr_rgb = 24'hABCDEF;
        ifc.commit = 1'b1; ifc.brightness = 8'd255;
        tick();
        ifc.wr_valid = 1'b0; ifc.commit = 1'b0;
        t0 = cyc;
        sync_at(49);
        chk("same_cycle_px15", 384'(ifc.framebuf[383:360]), 384'(24'hABCDEF));

        // Table: one pixel update, commit at a given brightness, sync later
        for (int i = 0; i < 6; i++) begin
            wr_px(vecs[i].idx, vecs[i].rgb);
            do_commit(vecs[i].bri);
            sync_at(vecs[i].sync_at);
`ifdef NEOPIXEL_FB_BRIGHTNESS_EN
            ex = vecs[i].exp_on;
`else
            ex = vecs[i].exp_off;
`endif
            chk($sformatf("vec%0d_pixel", i), 384'(px(ifc.framebuf, int'(vecs[i].idx))), 384'(ex));
            chk($sformatf("vec%0d_swap_done", i), 384'(ifc.swap_done), 384'(1));
        end

        // Reset mid-SCALE
        do_commit(8'd255);
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_framebuf", ifc.framebuf, '0);
        chk("rst_mid_busy", 384'(ifc.busy), 384'(0));
        chk("rst_mid_wr_ready", 384'(ifc.wr_ready), 384'(1));
        @(negedge clk);
        rst = 1'b0;
        ifc.frame_sync = 1'b1;
        tick(); tick();
        ifc.frame_sync = 1'b0;
        chk("rst_no_swap_done", 384'(ifc.swap_done), 384'(0));
        chk("rst_fb_stays_zero", ifc.framebuf, '0);
        do_commit(8'd255);
        sync_at(49);
        chk("rst_back_cleared", ifc.framebuf, '0);
        chk("rst_swap_after", 384'(ifc.swap_done), 384'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/neopixel_framebuf.md
# neopixel_framebuf

Double-buffered pixel store that sits directly upstream of the NeoPixel serialiser and drives its 384-bit `framebuf` input (16 LEDs × 24 bits). The pixel source writes individual pixels into a back buffer through a valid/ready port, then commits the frame. A sequential copy engine walks the 48 bytes of the back buffer, optionally applying global brightness scaling, into a staging buffer. Staging is swapped into the front buffer only on the serialiser's frame-sync pulse, so the serialiser never sees a torn frame.

## Interface
- `NUM_PIXELS`, 16: pixel count; fixed, because the output is 384 bits.
- `BYTES`, 48: `NUM_PIXELS` × 3.

- `clk`  in  1  serialiser-domain clock (800 kHz)
- `rst`  in  1  asynchronous, active-high reset
- `wr_valid`  in  1  pixel write request
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`
- `wr_index`  in  4  pixel number 0–15
- `wr_rgb`  in  24  pixel word {G[23:16], R[15:8], B[7:0]}
- `commit`  in  1  request to publish the back buffer; accepted only in IDLE
- `brightness`  in  8  global brightness, sampled when `commit` is accepted
- `frame_sync`  in  1  single-cycle pulse marking the downstream sync window
- `busy`  out  1  high in SCALE and WAIT_SYNC
- `swap_done`  out  1  one-cycle pulse on the cycle the front buffer is updated
- `framebuf`  out  384  front buffer; pixel i at [24i+23:24i], byte k at [8k+7:8k]

## Operation
- Storage: back, staging and front buffers, 384 bits each. All three reset to 0.
- FSM states:
  - **IDLE:** `wr_ready`=1. An accepted write sets back[24·idx +: 24] ← `wr_rgb`.
  - **IDLE → SCALE:** on `commit`. This also latches `brightness` into `bri_q` and clears `byte_ptr`.
  - **Same-cycle write and commit:** if a write and `commit` occur together in IDLE, the write lands first and is included in the frame.
  - **SCALE:** runs one byte per cycle, setting staging[byte_ptr] ← f(back[byte_ptr]). `byte_ptr` runs 0..47. After byte 47 the FSM moves to WAIT_SYNC. `wr_ready`=0.
  - **WAIT_SYNC:** holds until `frame_sync`=1, then front ← staging, `swap_done` pulses, and the FSM returns to IDLE.
- `frame_sync` outside WAIT_SYNC is ignored; no pending flag is kept.
- `commit` outside IDLE is ignored (not queued).
- `wr_valid` while `wr_ready`=0 is stalled. The source holds the request until it is accepted.
- The back buffer is never modified by the engine. Its contents persist across commits, so a partial update followed by a commit republishes the unchanged pixels.
- Arithmetic: f(x) = (x · (`bri_q` + 1)) >> 8.
  - The product is 17 bits and the result is truncated to 8 bits.
  - `bri_q`=255 gives identity; `bri_q`=0 gives x>>8, which is 0 for every x.
- Reset asserted mid-operation: all buffers clear, the FSM returns to IDLE and `framebuf` goes to 0 immediately (asynchronous).

## Timing
- **Reset values:** `framebuf`=0, `wr_ready`=1, `busy`=0, `swap_done`=0.
- **Write latency:** a write accepted at edge T is visible in the back buffer after T. It is not visible on `framebuf` until a commit/swap.
- **Commit:** accepted at edge T, so `busy`=1 from T. SCALE occupies edges T+1..T+48, and WAIT_SYNC starts at T+49.
- **Swap:** with `frame_sync` high at edge S ≥ T+49, `framebuf` updates at S. In the cycle after S, `swap_done`=1, `busy`=0 and `wr_ready`=1.
- **Minimum latency:** commit-to-`framebuf` is 49 cycles.
- **Throughput:** one pixel write per cycle in IDLE.
- All outputs are registered except `wr_ready` and `busy`, which decode the state register directly.

## Configuration
- `NEOPIXEL_FB_BRIGHTNESS_EN` defined: f as above.
- Not defined: f(x) = x.
  - `brightness` and `bri_q` are unused.
  - FSM, SCALE length and all timing are identical.

## Test plan
- **Reset:** assert `rst` mid-SCALE → `framebuf`=0, `busy`=0 and `wr_ready`=1 immediately. No `swap_done` follows.
- **Basic frame:** write pixel 3 = 0x112233, commit with `brightness`=255, pulse `frame_sync` at T+60 → `framebuf`[95:72]=0x112233 and all other bits 0. `swap_done` is a single pulse.
- **Sync gating:** pulse `frame_sync` at T+20, during SCALE → no swap. A pulse at T+49 → swap, with `framebuf` valid after that edge.
- **Brightness (macro on):** all pixels 0xFFFFFF, `brightness`=127 → every byte 0x7F. With `brightness`=0 → every byte 0x00.
- **Backpressure:** hold `wr_valid` during `busy` → no write occurs until IDLE. Then exactly one write is accepted. A `commit` during `busy` is ignored.
- **Same cycle:** a write to pixel 15 = 0xABCDEF together with `commit` → published frame has bits [383:360]=0xABCDEF.
- **Macro off:** `brightness`=0 with pixel data 0x808080 → published unchanged.
